fft_addr_ctrl: RTL
==================

# fft_addr_ctrl

Sequencer for the in-place radix-2 DIT FFT core. On `start` it walks all LOG2N stages and N/2 butterflies per stage, issuing one butterfly per accepted cycle: two data-memory addresses and a twiddle ROM index. It inserts a fixed drain gap after each stage so that butterfly write-back completes before the next stage reads. It sits between the top-level control and the butterfly/memory datapath.

## Interface
- `LOG2N`, 12: log2 of transform length N; range 2..ADDR_WIDTH.
- `ADDR_WIDTH`, 12: data memory address width; must be >= LOG2N.
- `BF_LATENCY`, 4: butterfly read-to-write-back latency in cycles; range 0..15.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a transform; sampled only in IDLE.
- `abort` in 1: synchronous cancel; highest priority.
- `out_ready` in 1: datapath accepts the current butterfly.
- `out_valid` out 1: addr_a/addr_b/tw_idx are valid.
- `addr_a` out ADDR_WIDTH: upper-wing address.
- `addr_b` out ADDR_WIDTH: lower-wing address.
- `tw_idx` out LOG2N-1: twiddle index, W_N^tw_idx.
- `stage` out 4: current stage number, 0..LOG2N-1.
- `busy` out 1: high in ISSUE, DRAIN or DONE.
- `done` out 1: one-cycle pulse at completion.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- Internal counters: stage s (4 bits) and butterfly b (LOG2N-1 bits).
- Butterfly fields: half = 1<<s, j = b>>s, k = b & (half-1).
- addr_a = (j<<(s+1)) | k, zero-extended to ADDR_WIDTH.
- addr_b = addr_a | half. Bit s of addr_a is always 0, so no carry is needed.
- tw_idx = k<<(LOG2N-1-s).
- IDLE: start=1 clears s and b, then goes to ISSUE.
- ISSUE: out_valid=1. A butterfly is accepted when out_valid && out_ready.
  - Accept with b < N/2-1: b increments.
  - Accept of the last butterfly (b = N/2-1): b clears, then go to DRAIN. If BF_LATENCY=0, go directly to the next-stage ISSUE, or to DONE after the last stage.
- DRAIN: out_valid=0 for exactly BF_LATENCY cycles. Then s increments and the state returns to ISSUE, or goes to DONE if s was LOG2N-1.
- DONE: done=1 for one cycle, then IDLE.
- Stall handling: while out_valid=1 and out_ready=0, the outputs and counters hold stable (valid/ready rule, no retraction).
- abort: in any state, the next state is IDLE with counters cleared and no done pulse. This covers an abort coinciding with an accept or with the last drain cycle.
- start while busy is ignored.
- start and abort together in IDLE: abort wins and the block stays IDLE.

## Timing
- Reset values: out_valid=0, addr_a=0, addr_b=0, tw_idx=0, stage=0, busy=0, done=0, state=IDLE, drain counter=0.
- All outputs are registered.
- start sampled at edge 0 gives out_valid=1 and busy=1 from cycle 1.
- With out_ready held high, one butterfly issues per cycle.
- With out_ready held high, done is high in cycle LOG2N*(N/2+BF_LATENCY)+1 counted from the start edge. busy falls in the following cycle.
- Each cycle with out_ready low adds one cycle to the total.
- A new start is accepted in the cycle after done, i.e. the first IDLE cycle.
- Asynchronous reset mid-run returns all outputs to their reset values immediately. Memory contents are the datapath's concern.

## Configuration
- `FFT_ADDR_CTRL_STALL_CNT_EN`
  - Defined: adds output `stall_cnt` [15:0]. It counts cycles with out_valid=1 && out_ready=0, saturates at 16'hFFFF, clears on an accepted start, holds after done, and resets to 0.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- LOG2N=3, BF_LATENCY=2, out_ready=1, pulse start.
  - Stage 0: (a,b,tw) = (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - out_valid is low in cycles 5-6, 11-12 and 17-18; done is high in cycle 19 only.
- Same configuration, out_ready low in cycles 2-4:
  - outputs hold (2,3,0) during the stall; the sequence is otherwise unchanged.
  - done moves to cycle 22; stall_cnt=3 when the macro is defined.
- BF_LATENCY=0, LOG2N=3: no bubbles; 12 back-to-back butterflies; done in cycle 13.
- abort in cycle 8 of run 1, then start in cycle 10:
  - no done pulse is seen for the aborted run.
  - the new run restarts at (0,1,0) with stage=0 in cycle 11.
- start pulsed during ISSUE is ignored. rst_n asserted mid-DRAIN forces all outputs to 0 asynchronously; after release the block is IDLE.
- LOG2N=12, out_ready random at 70% high: a scoreboard checks all 6×2048... i.e. 12×2048 address pairs against the reference formula, with every address hit exactly once per stage.

Source files
------------

// File: rtl/fft_addr_ctrl.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT, with a drain gap after each stage.
// Optional stall counter output enabled by defining FFT_ADDR_CTRL_STALL_CNT_EN.
module fft_addr_ctrl #(
  parameter int unsigned LOG2N      = 12,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned BF_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [LOG2N-2:0]      tw_idx,
  output logic [3:0]            stage,
  output logic                  busy,
  output logic                  done
`ifdef FFT_ADDR_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int unsigned BW = LOG2N - 1;
  localparam int unsigned SW = 4;
  localparam int unsigned DW = 4;
  localparam logic [BW-1:0] B_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'((BF_LATENCY == 0) ? 0 : BF_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         s_q, s_d;
  logic [BW-1:0]         b_q, b_d;
  logic [DW-1:0]         dcnt_q, dcnt_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d, bb_q, bb_d;
  logic [BW-1:0]         tw_q, tw_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  stage_end;
  logic [ADDR_WIDTH-1:0] fld_half, fld_k, fld_a;

  assign accept = valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      dcnt_q  <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      bb_q    <= '0;
      tw_q    <= '0;
      stage_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      dcnt_q  <= dcnt_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      bb_q    <= bb_d;
      tw_q    <= tw_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state and counters; abort overrides everything, including an accept in the same cycle.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    b_d       = b_q;
    dcnt_d    = dcnt_q;
    stage_end = 1'b0;
    if (abort) begin
      state_d = IDLE;
      s_d     = '0;
      b_d     = '0;
      dcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ISSUE;
            s_d     = '0;
            b_d     = '0;
          end
        end
        ISSUE: begin
          if (accept) begin
            if (b_q == B_LAST) begin
              b_d = '0;
              if (BF_LATENCY == 0) begin
                stage_end = 1'b1;
              end else begin
                state_d = DRAIN;
                dcnt_d  = '0;
              end
            end else begin
              b_d = b_q + BW'(1);
            end
          end
        end
        DRAIN: begin
          if (dcnt_q == D_LAST) begin
            dcnt_d    = '0;
            stage_end = 1'b1;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
          s_d     = '0;
        end
        default: state_d = IDLE;
      endcase
      if (stage_end) begin
        if (s_q == S_LAST) begin
          state_d = DONE;
        end else begin
          state_d = ISSUE;
          s_d     = s_q + SW'(1);
        end
      end
    end
  end

  // Registered outputs derived from next-cycle counters; bit s of addr_a is always clear.
  always_comb begin
    fld_half = ADDR_WIDTH'(1) << s_d;
    fld_k    = ADDR_WIDTH'(b_d) & (fld_half - ADDR_WIDTH'(1));
    fld_a    = ((ADDR_WIDTH'(b_d) >> s_d) << (s_d + SW'(1))) | fld_k;
    valid_d  = (state_d == ISSUE);
    a_d      = valid_d ? fld_a : '0;
    bb_d     = valid_d ? (fld_a | fld_half) : '0;
    tw_d     = valid_d ? BW'(fld_k << (S_LAST - s_d)) : '0;
    stage_d  = s_d;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  assign out_valid = valid_q;
  assign addr_a    = a_q;
  assign addr_b    = bb_q;
  assign tw_idx    = tw_q;
  assign stage     = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef FFT_ADDR_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of back-pressured cycles, cleared by an accepted start.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == IDLE) && start && !abort) begin
      stall_cnt_d = '0;
    end else if (valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
